muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-bit multiply/divide unit with HI/LO result registers.
// MULT/MULTU take two cycles. DIV/DIVU run a restoring divider, one quotient
// bit per cycle, followed by a sign-fixup cycle.
// Optional feature macro: MULDIV_DIV_EN. When it is defined, the divider is
// built. When it is undefined, DIV/DIVU complete as reserved ops.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic signed [63:0] prod_q, prod_d;
    logic signed [63:0] mul_a, mul_b;

`ifdef MULDIV_DIV_EN
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic [32:0] rem_sh, diff;
    logic        div_signed;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        // 0x80000000 maps to itself, which is the correct unsigned magnitude.
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        mul_a   = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'b0, a};
        mul_b   = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'b0, b};
`ifdef MULDIV_DIV_EN
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        rem_sh     = {rem_q, quo_q[31]};
        diff       = rem_sh - {1'b0, dvs_q};
        div_signed = (op == OP_DIV);
`endif
        if (flush) begin
            // Flush aborts anything in flight; hi/lo are never touched.
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                prod_d  = mul_a * mul_b;
                                state_d = MUL;
                                busy_d  = 1'b1;
                            end
                            OP_MTHI: begin
                                hi_d   = a;
                                done_d = 1'b1;
                            end
                            OP_MTLO: begin
                                lo_d   = a;
                                done_d = 1'b1;
                            end
`ifdef MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                busy_d = 1'b1;
                                cnt_d  = 5'd0;
                                if (b == 32'd0) begin
                                    // Divide by zero goes straight to FIX,
                                    // which then writes hi=a, lo=all ones.
                                    rem_d   = a;
                                    quo_d   = 32'hFFFF_FFFF;
                                    neg_q_d = 1'b0;
                                    neg_r_d = 1'b0;
                                    state_d = FIX;
                                end else begin
                                    rem_d   = 32'd0;
                                    quo_d   = div_signed ? abs32(a) : a;
                                    dvs_d   = div_signed ? abs32(b) : b;
                                    neg_q_d = div_signed & (a[31] ^ b[31]);
                                    neg_r_d = div_signed & a[31];
                                    state_d = DIV;
                                end
                            end
`endif
                            default: done_d = 1'b1;
                        endcase
                    end
                end
                MUL: begin
                    hi_d    = prod_q[63:32];
                    lo_d    = prod_q[31:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    // The dividend shifts out of quo while quotient bits
                    // shift in from the bottom.
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        cnt_d   = 5'd0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    hi_d    = fix_sign(rem_q, neg_r_q);
                    lo_d    = fix_sign(quo_q, neg_q_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`endif
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register: reset clears control and the architectural hi/lo
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            prod_q  <= 64'sd0;
`ifdef MULDIV_DIV_EN
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
`ifdef MULDIV_DIV_EN
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit. Inputs are driven and outputs sampled
// on the falling edge. "Cycle N" means N rising edges after the start cycle.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one cycle; returns in the middle of cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step until done is seen or the budget runs out; returns the cycle number.
    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int nb;
        int nd;
        int hchg;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        // MULT -2 * 3
        issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_busy_c1", {31'd0, busy}, 32'd1);
        chk("mult_done_c1", {31'd0, done}, 32'd0);
        wait_done(1, cyc);
        chk("mult_done_cyc", cyc, 32'd2);
        chk("mult_busy_c2", {31'd0, busy}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU same operands
        issue(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(1, cyc);
        chk("multu_done_cyc", cyc, 32'd2);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // MTHI / MTLO
        issue(3'b100, 32'hA5A5_A5A5, 32'd0);
        chk("mthi_done_c1", {31'd0, done}, 32'd1);
        chk("mthi_busy_c1", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mthi_lo", lo, 32'hFFFF_FFFA);
        issue(3'b101, 32'h0000_1111, 32'd0);
        chk("mtlo_done_c1", {31'd0, done}, 32'd1);
        chk("mtlo_lo", lo, 32'h0000_1111);
        chk("mtlo_hi", hi, 32'hA5A5_A5A5);

        // Reserved ops
        issue(3'b110, 32'h0000_0BAD, 32'd1);
        chk("rsv6_done_c1", {31'd0, done}, 32'd1);
        chk("rsv6_hi", hi, 32'hA5A5_A5A5);
        chk("rsv6_lo", lo, 32'h0000_1111);
        issue(3'b111, 32'h0000_0BAD, 32'd1);
        chk("rsv7_done_c1", {31'd0, done}, 32'd1);
        chk("rsv7_busy_c1", {31'd0, busy}, 32'd0);

        // Flush together with start: start dropped
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h0000_0099; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("fls_start_done", {31'd0, done}, 32'd0);
        chk("fls_start_hi", hi, 32'hA5A5_A5A5);

        // Flush at the MULT completion edge suppresses the write
        issue(3'b000, 32'd5, 32'd6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fls_mul_busy", {31'd0, busy}, 32'd0);
        chk("fls_mul_done", {31'd0, done}, 32'd0);
        chk("fls_mul_hi", hi, 32'hA5A5_A5A5);
        chk("fls_mul_lo", lo, 32'h0000_1111);

        // Plain MULT 5*6
        issue(3'b000, 32'd5, 32'd6);
        wait_done(1, cyc);
        chk("mul56_hi", hi, 32'd0);
        chk("mul56_lo", lo, 32'd30);

`ifdef MULDIV_DIV_EN
        // DIV -7 / 2: busy in cycles 1..33, done in cycle 34
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        nb = 0; hchg = 0;
        for (int i = 1; i <= 33; i++) begin
            if (busy === 1'b1) nb++;
            if (hi !== 32'd0 || lo !== 32'd30) hchg++;
            @(negedge clk);
        end
        chk("div_busy_cycles", nb, 32'd33);
        chk("div_hilo_stable", hchg, 32'd0);
        chk("div_done_c34", {31'd0, done}, 32'd1);
        chk("div_busy_c34", {31'd0, busy}, 32'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        issue(3'b011, 32'd7, 32'd2);
        wait_done(1, cyc);
        chk("divu_done_cyc", cyc, 32'd34);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // Divide by zero
        issue(3'b010, 32'h0000_1234, 32'd0);
        wait_done(1, cyc);
        chk("dz_done_cyc", cyc, 32'd2);
        chk("dz_hi", hi, 32'h0000_1234);
        chk("dz_lo", lo, 32'hFFFF_FFFF);

        // Overflow case
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, cyc);
        chk("ovf_done_cyc", cyc, 32'd34);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // Flush in cycle 10 of a DIV
        issue(3'b010, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fls_div_busy_c11", {31'd0, busy}, 32'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("fls_div_no_done", nd, 32'd0);
        chk("fls_div_hi", hi, 32'd0);
        chk("fls_div_lo", lo, 32'h8000_0000);

        // Start while busy is ignored
        issue(3'b011, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, cyc);
        chk("ign_done_cyc", cyc, 32'd34);
        chk("ign_hi", hi, 32'd2);
        chk("ign_lo", lo, 32'd14);

        // Back-to-back MULT in the DIV done cycle
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_c1", {31'd0, busy}, 32'd1);
        wait_done(1, cyc);
        chk("b2b_done_cyc", cyc, 32'd2);
        chk("b2b_lo", lo, 32'd30);

        // Reset in cycle 5 of a DIV
        issue(3'b010, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstdiv_busy", {31'd0, busy}, 32'd0);
        chk("rstdiv_hi", hi, 32'd0);
        chk("rstdiv_lo", lo, 32'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("rstdiv_no_done", nd, 32'd0);
`else
        // Divider not built: DIV/DIVU act as reserved ops
        issue(3'b010, 32'd7, 32'd2);
        chk("nodiv_done_c1", {31'd0, done}, 32'd1);
        chk("nodiv_busy_c1", {31'd0, busy}, 32'd0);
        chk("nodiv_hi", hi, 32'd0);
        chk("nodiv_lo", lo, 32'd30);
        issue(3'b011, 32'd7, 32'd2);
        chk("nodivu_done_c1", {31'd0, done}, 32'd1);
        chk("nodivu_busy_c1", {31'd0, busy}, 32'd0);
        chk("nodivu_lo", lo, 32'd30);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
